nfc_cmd_dispatch: RTL and testbench
===================================

# nfc_cmd_dispatch

Multi-channel NFC command dispatcher between the AXI-Lite register file and `CHAN_NUM` instances of `nfc_channel_test`, all clocked on `nand_usr_clk`. It decodes the target channel from the command LBA and buffers commands in a per-channel FIFO of depth `FIFO_DEPTH`. It issues them on per-channel valid/ready handshakes and aggregates back-pressure, error and status signals into one register-file view. It generalises the fixed single-channel hookup to N channels with queuing.

## Interface
- `CHAN_NUM`, 2: number of channels, 1..8.
- `FIFO_DEPTH`, 4: per-channel command FIFO depth, power of 2, 2..16.
- `AF_LEVEL`, 3: per-channel occupancy at or above which `o_almost_full` asserts; must be ≤ `FIFO_DEPTH`.
- `CHAN_SEL_LSB`, 40: LSB of the channel field within `i_lba`.
- `CSW`: derived, not user-set: max(1, clog2(`CHAN_NUM`)).

- `nand_usr_clk`  in  1  sole clock.
- `nand_usr_rstn`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  single-cycle command strobe; there is no ready signal.
- `i_opc`  in  16  opcode.
- `i_lba`  in  48  LBA; the channel number is `i_lba[CHAN_SEL_LSB +: CSW]`.
- `i_len`  in  24  length.
- `o_almost_full`  out  1  any channel FIFO count ≥ `AF_LEVEL`.
- `o_chan_valid`  out  `CHAN_NUM`  per-channel command valid.
- `i_chan_ready`  in  `CHAN_NUM`  per-channel ready, driven from the channel's `o_ready`.
- `o_chan_opc` / `o_chan_lba` / `o_chan_len`  out  `CHAN_NUM`×16 / ×48 / ×24  packed per-channel command fields.
- `i_chan_sr`  in  `CHAN_NUM`×8  per-channel NAND status register.
- `i_chan_status`  in  `CHAN_NUM`×2  per-channel status.
- `i_status_sel`  in  `CSW`  selects which channel's status appears on `o_sr` / `o_status`.
- `o_sr`  out  8  registered, muxed SR.
- `o_status`  out  2  registered, muxed status.
- `o_busy`  out  1  any FIFO non-empty.
- `o_drop_cnt`  out  16  saturating count of rejected commands.
- `o_err`  out  2  sticky error bits: [0] FIFO overflow, [1] bad channel number.
- `i_err_clr`  in  1  clears `o_err` and `o_drop_cnt`.

## Operation
- **Decode:** on `i_valid`, compute ch = `i_lba[CHAN_SEL_LSB +: CSW]`.
  - If ch ≥ `CHAN_NUM`: reject the command, set `o_err[1]`, increment `o_drop_cnt`.
- **Push:** if FIFO[ch] count (value registered before this edge) < `FIFO_DEPTH`, write {opc, lba, len} and increment the count.
  - Otherwise reject, set `o_err[0]`, increment `o_drop_cnt`.
  - A pop on the same cycle does not rescue a push to a full FIFO.
- **Pop:** `o_chan_valid[c]` = FIFO[c] non-empty. Data is show-ahead, taken from the head entry.
  - When valid is low, the data fields are driven to 0.
  - `o_chan_valid[c] & i_chan_ready[c]` pops one entry.
  - Valid and data stay stable until the handshake completes.
- **Simultaneous push and pop** on a non-full FIFO: the count is unchanged and both operations take effect. Pointers wrap modulo `FIFO_DEPTH`.
- **Channel independence:** channels operate independently; a stalled channel never blocks another.
- **Status:** `o_sr` / `o_status` are registered each cycle from the channel selected by `i_status_sel`. A selection ≥ `CHAN_NUM` yields 0.
- **Drop counter:** `o_drop_cnt` saturates at 0xFFFF.
  - `i_err_clr` has priority over a same-cycle increment or error set: the result is 0.
- **Aggregates:** `o_almost_full` and `o_busy` are combinational from the registered counts.

## Timing
- **Reset values:** all counts and pointers 0; `o_chan_valid` 0; all data outputs 0; `o_sr` 0, `o_status` 0; `o_drop_cnt` 0, `o_err` 0; `o_almost_full` 0, `o_busy` 0. FIFO storage is not reset.
- **Latency:** `i_valid` sampled at edge N → `o_chan_valid[ch]` high after edge N, with a 1-cycle minimum.
- **Throughput:** one command per cycle per channel (back-to-back pop with ready held high).
- **`o_almost_full`:** rises in the cycle after the push that reaches `AF_LEVEL`. The register file must stop issuing while it is high; commands issued in that same cycle are still accepted while space remains.
- **Status path:** `o_sr` / `o_status` have 1-cycle latency from `i_status_sel` or the status inputs.
- **Reset mid-operation:** asserting reset flushes all queued commands and deasserts all outputs asynchronously. After release, nothing is replayed.

## Test plan
- **Single routing:** reset, then `i_lba`=0x0100_0000_0000 (ch=1), opc=0x0030, len=0x1000, with `i_chan_ready`=0 → `o_chan_valid`=2'b10 one cycle later and the fields match. Raise ready[1] → one pop, `o_busy`=0.
- **Overflow:** with ready low, push 5 commands to ch0 (depth 4) → `o_almost_full`=1 after the 3rd push, 4 entries queued, 5th dropped, `o_err`=2'b01, `o_drop_cnt`=1. Drain → FIFO order preserved.
- **Bad channel:** with `CHAN_NUM`=3, send lba channel field=3 → no valid asserts, `o_err[1]`=1, `o_drop_cnt` increments. Then pulse `i_err_clr` → all 0.
- **Full plus pop:** with ch0 full, push and pop on the same cycle → push dropped, count becomes 3. With ch0 at count 2, push and pop on the same cycle → count stays 2.
- **Independence:** ch0 ready stuck low while ch1 receives 10 commands with ready high → ch1 pops all 10, one per cycle; ch0 is unaffected.
- **Status and reset:** set `i_chan_sr`={0xE0, 0xC0} and step `i_status_sel` 0→1 → `o_sr` goes 0xC0 then 0xE0 with 1-cycle lag. Assert reset with 2 commands queued → all outputs 0 immediately and nothing re-emerges after release.

Source files
------------

// File: rtl/nfc_cmd_dispatch.sv
// nfc_cmd_dispatch
// Routes commands from the register file to CHAN_NUM NFC channels. The target
// channel comes from a field of the LBA. Each channel has its own show-ahead
// command FIFO, drained over a valid/ready handshake. Back-pressure, error and
// status information from all channels is folded into one register-file view.
//
// Ports
//   nand_usr_clk, nand_usr_rstn     clock, async active-low reset
//   i_valid/i_opc/i_lba/i_len       command strobe and fields (no ready)
//   o_almost_full, o_busy           aggregate FIFO occupancy flags
//   o_chan_valid, i_chan_ready      per-channel handshake
//   o_chan_opc/_lba/_len            packed per-channel head-of-queue fields
//   i_chan_sr, i_chan_status        per-channel status inputs
//   i_status_sel, o_sr, o_status    registered status mux
//   o_drop_cnt, o_err, i_err_clr    rejected-command counter, sticky errors
module nfc_cmd_dispatch #(
  parameter int CHAN_NUM     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int AF_LEVEL     = 3,
  parameter int CHAN_SEL_LSB = 40,
  localparam int CSW         = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1
) (
  input  logic                   nand_usr_clk,
  input  logic                   nand_usr_rstn,
  input  logic                   i_valid,
  input  logic [15:0]            i_opc,
  input  logic [47:0]            i_lba,
  input  logic [23:0]            i_len,
  output logic                   o_almost_full,
  output logic [CHAN_NUM-1:0]    o_chan_valid,
  input  logic [CHAN_NUM-1:0]    i_chan_ready,
  output logic [CHAN_NUM*16-1:0] o_chan_opc,
  output logic [CHAN_NUM*48-1:0] o_chan_lba,
  output logic [CHAN_NUM*24-1:0] o_chan_len,
  input  logic [CHAN_NUM*8-1:0]  i_chan_sr,
  input  logic [CHAN_NUM*2-1:0]  i_chan_status,
  input  logic [CSW-1:0]         i_status_sel,
  output logic [7:0]             o_sr,
  output logic [1:0]             o_status,
  output logic                   o_busy,
  output logic [15:0]            o_drop_cnt,
  output logic [1:0]             o_err,
  input  logic                   i_err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 16 + 48 + 24;

  logic [DW-1:0] mem    [CHAN_NUM][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [CHAN_NUM];
  logic [PW-1:0] rd_ptr [CHAN_NUM];
  logic [CW-1:0] cnt    [CHAN_NUM];

  logic [CSW-1:0]      ch_sel;
  logic                bad_ch;
  logic                ovf;
  logic                drop;
  logic [CHAN_NUM-1:0] push;
  logic [CHAN_NUM-1:0] pop;
  logic [7:0]          sr_mux;
  logic [1:0]          status_mux;

  // Decode and accept/reject. Fullness uses the registered count only, so a
  // pop in the same cycle cannot make room for a push.
  always_comb begin
    ch_sel = i_lba[CHAN_SEL_LSB +: CSW];
    bad_ch = 1'b1;
    ovf    = 1'b0;
    push   = '0;
    pop    = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      if (ch_sel == CSW'(c)) begin
        bad_ch = 1'b0;
        if (i_valid) begin
          if (cnt[c] == CW'(FIFO_DEPTH)) ovf = 1'b1;
          else                           push[c] = 1'b1;
        end
      end
      pop[c] = (cnt[c] != '0) && i_chan_ready[c];
    end
    drop = (i_valid && bad_ch) || ovf;
  end

  always_ff @(posedge nand_usr_clk or negedge nand_usr_rstn) begin
    if (!nand_usr_rstn) begin
      for (int c = 0; c < CHAN_NUM; c++) begin
        cnt[c]    <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHAN_NUM; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
        case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + CW'(1);
          2'b01:   cnt[c] <= cnt[c] - CW'(1);
          default: cnt[c] <= cnt[c];
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset; pointers/counts define validity.
  always_ff @(posedge nand_usr_clk) begin
    for (int c = 0; c < CHAN_NUM; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= {i_opc, i_lba, i_len};
    end
  end

  // Show-ahead outputs, zeroed while the queue is empty.
  always_comb begin
    o_chan_valid  = '0;
    o_chan_opc    = '0;
    o_chan_lba    = '0;
    o_chan_len    = '0;
    o_almost_full = 1'b0;
    o_busy        = 1'b0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      if (cnt[c] != '0) begin
        o_chan_valid[c]       = 1'b1;
        o_chan_opc[c*16 +: 16] = mem[c][rd_ptr[c]][DW-1 -: 16];
        o_chan_lba[c*48 +: 48] = mem[c][rd_ptr[c]][24 +: 48];
        o_chan_len[c*24 +: 24] = mem[c][rd_ptr[c]][0 +: 24];
        o_busy                = 1'b1;
      end
      if (cnt[c] >= CW'(AF_LEVEL)) o_almost_full = 1'b1;
    end
  end

  // Clear wins over any same-cycle increment or error set.
  always_ff @(posedge nand_usr_clk or negedge nand_usr_rstn) begin
    if (!nand_usr_rstn) begin
      o_drop_cnt <= '0;
      o_err      <= '0;
    end else if (i_err_clr) begin
      o_drop_cnt <= '0;
      o_err      <= '0;
    end else begin
      if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
      if (ovf)                 o_err[0] <= 1'b1;
      if (i_valid && bad_ch)   o_err[1] <= 1'b1;
    end
  end

  // Out-of-range selections fall through the loop and read as 0.
  always_comb begin
    sr_mux     = '0;
    status_mux = '0;
    for (int c = 0; c < CHAN_NUM; c++) begin
      if (i_status_sel == CSW'(c)) begin
        sr_mux     = i_chan_sr[c*8 +: 8];
        status_mux = i_chan_status[c*2 +: 2];
      end
    end
  end

  always_ff @(posedge nand_usr_clk or negedge nand_usr_rstn) begin
    if (!nand_usr_rstn) begin
      o_sr     <= '0;
      o_status <= '0;
    end else begin
      o_sr     <= sr_mux;
      o_status <= status_mux;
    end
  end

endmodule

// File: tb/tb_nfc_cmd_dispatch.sv
// Directed bench for nfc_cmd_dispatch with three channels, so that channel
// field value 3 exercises the bad-channel path.
module tb_nfc_cmd_dispatch;

  localparam int CN = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic [15:0]   i_opc;
  logic [47:0]   i_lba;
  logic [23:0]   i_len;
  logic          o_almost_full;
  logic [CN-1:0] o_chan_valid;
  logic [CN-1:0] i_chan_ready;
  logic [CN*16-1:0] o_chan_opc;
  logic [CN*48-1:0] o_chan_lba;
  logic [CN*24-1:0] o_chan_len;
  logic [CN*8-1:0]  i_chan_sr;
  logic [CN*2-1:0]  i_chan_status;
  logic [1:0]    i_status_sel;
  logic [7:0]    o_sr;
  logic [1:0]    o_status;
  logic          o_busy;
  logic [15:0]   o_drop_cnt;
  logic [1:0]    o_err;
  logic          i_err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  nfc_cmd_dispatch #(.CHAN_NUM(CN), .FIFO_DEPTH(4), .AF_LEVEL(3), .CHAN_SEL_LSB(40)) dut (
    .nand_usr_clk(clk), .nand_usr_rstn(rst_n),
    .i_valid(i_valid), .i_opc(i_opc), .i_lba(i_lba), .i_len(i_len),
    .o_almost_full(o_almost_full), .o_chan_valid(o_chan_valid), .i_chan_ready(i_chan_ready),
    .o_chan_opc(o_chan_opc), .o_chan_lba(o_chan_lba), .o_chan_len(o_chan_len),
    .i_chan_sr(i_chan_sr), .i_chan_status(i_chan_status), .i_status_sel(i_status_sel),
    .o_sr(o_sr), .o_status(o_status), .o_busy(o_busy),
    .o_drop_cnt(o_drop_cnt), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] mk_lba(input logic [1:0] ch, input logic [39:0] lo);
    return {6'b0, ch, lo};
  endfunction

  task automatic push(input logic [1:0] ch, input logic [15:0] opc);
    i_valid = 1'b1;
    i_opc   = opc;
    i_lba   = mk_lba(ch, {24'h0, opc});
    i_len   = {8'h0, opc};
    step();
    i_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++; if (o_chan_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b exp 000", o_chan_valid); end
    n_tests++; if ({o_busy, o_almost_full, o_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {o_busy, o_almost_full, o_err}); end
    n_tests++; if ({o_drop_cnt, o_sr, o_status} !== 26'h0) begin n_fail++; $display("FAIL reset_cnt_sr got %h exp 0", {o_drop_cnt, o_sr, o_status}); end
    n_tests++; if ({o_chan_opc, o_chan_lba, o_chan_len} !== '0) begin n_fail++; $display("FAIL reset_data got nonzero exp 0"); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    i_valid = 1'b1; i_opc = 16'h0030; i_lba = 48'h0100_0000_0000; i_len = 24'h001000;
    step();
    i_valid = 1'b0;
    n_tests++; if (o_chan_valid !== 3'b010) begin n_fail++; $display("FAIL single_valid got %b exp 010", o_chan_valid); end
    n_tests++; if (o_chan_opc[31:16] !== 16'h0030) begin n_fail++; $display("FAIL single_opc got %h exp 0030", o_chan_opc[31:16]); end
    n_tests++; if (o_chan_lba[95:48] !== 48'h0100_0000_0000) begin n_fail++; $display("FAIL single_lba got %h exp 010000000000", o_chan_lba[95:48]); end
    n_tests++; if (o_chan_len[47:24] !== 24'h001000) begin n_fail++; $display("FAIL single_len got %h exp 001000", o_chan_len[47:24]); end
    n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", o_busy); end
    step();
    n_tests++; if (o_chan_valid !== 3'b010) begin n_fail++; $display("FAIL single_hold got %b exp 010", o_chan_valid); end
    i_chan_ready = 3'b010;
    step();
    i_chan_ready = 3'b000;
    n_tests++; if ({o_chan_valid, o_busy} !== 4'b0000) begin n_fail++; $display("FAIL single_pop got %b exp 0000", {o_chan_valid, o_busy}); end
    n_tests++; if (o_chan_opc[31:16] !== 16'h0) begin n_fail++; $display("FAIL single_zero_data got %h exp 0000", o_chan_opc[31:16]); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      push(2'd0, 16'h0010 + 16'(i));
      if (i == 1) begin
        n_tests++; if (o_almost_full !== 1'b0) begin n_fail++; $display("FAIL ovf_af_early got %b exp 0", o_almost_full); end
      end
      if (i == 2) begin
        n_tests++; if (o_almost_full !== 1'b1) begin n_fail++; $display("FAIL ovf_af_at3 got %b exp 1", o_almost_full); end
      end
    end
    n_tests++; if (o_err !== 2'b01) begin n_fail++; $display("FAIL ovf_err got %b exp 01", o_err); end
    n_tests++; if (o_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_drop got %0d exp 1", o_drop_cnt); end
    i_chan_ready = 3'b001;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (o_chan_valid[0] !== 1'b1 || o_chan_opc[15:0] !== 16'h0010 + 16'(i)) begin
        n_fail++; $display("FAIL ovf_drain%0d got v=%b opc=%h exp v=1 opc=%h", i, o_chan_valid[0], o_chan_opc[15:0], 16'h0010 + 16'(i));
      end
      step();
    end
    i_chan_ready = 3'b000;
    n_tests++; if ({o_chan_valid, o_almost_full, o_busy} !== 5'b0) begin n_fail++; $display("FAIL ovf_empty got %b exp 00000", {o_chan_valid, o_almost_full, o_busy}); end
  endtask

  task automatic test_bad_channel();
    pulse_clr();
    n_tests++; if ({o_err, o_drop_cnt} !== 18'h0) begin n_fail++; $display("FAIL clr1 got %h exp 0", {o_err, o_drop_cnt}); end
    push(2'd3, 16'h00BB);
    n_tests++; if ({o_chan_valid, o_busy} !== 4'b0) begin n_fail++; $display("FAIL bad_valid got %b exp 0000", {o_chan_valid, o_busy}); end
    n_tests++; if (o_err !== 2'b10) begin n_fail++; $display("FAIL bad_err got %b exp 10", o_err); end
    n_tests++; if (o_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL bad_drop got %0d exp 1", o_drop_cnt); end
    push(2'd3, 16'h00BC);
    n_tests++; if (o_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL bad_drop2 got %0d exp 2", o_drop_cnt); end
    // clear in the same cycle as another rejected command
    i_err_clr = 1'b1;
    push(2'd3, 16'h00BD);
    i_err_clr = 1'b0;
    n_tests++; if ({o_err, o_drop_cnt} !== 18'h0) begin n_fail++; $display("FAIL clr_prio got %h exp 0", {o_err, o_drop_cnt}); end
  endtask

  task automatic test_full_plus_pop();
    for (int i = 0; i < 4; i++) push(2'd0, 16'h0020 + 16'(i));
    i_valid = 1'b1; i_opc = 16'h0099; i_lba = mk_lba(2'd0, 40'h99); i_len = 24'h99;
    i_chan_ready = 3'b001;
    step();
    i_valid = 1'b0; i_chan_ready = 3'b000;
    n_tests++; if (o_err !== 2'b01 || o_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL fpp_drop got err=%b cnt=%0d exp err=01 cnt=1", o_err, o_drop_cnt); end
    i_chan_ready = 3'b001;
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (o_chan_valid[0] !== 1'b1 || o_chan_opc[15:0] !== 16'h0020 + 16'(i)) begin
        n_fail++; $display("FAIL fpp_drain%0d got v=%b opc=%h exp v=1 opc=%h", i, o_chan_valid[0], o_chan_opc[15:0], 16'h0020 + 16'(i));
      end
      step();
    end
    i_chan_ready = 3'b000;
    n_tests++; if (o_chan_valid[0] !== 1'b0) begin n_fail++; $display("FAIL fpp_count3 got %b exp 0", o_chan_valid[0]); end
    pulse_clr();
    push(2'd0, 16'h0030);
    push(2'd0, 16'h0031);
    i_valid = 1'b1; i_opc = 16'h0032; i_lba = mk_lba(2'd0, 40'h32); i_len = 24'h32;
    i_chan_ready = 3'b001;
    step();
    i_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      n_tests++;
      if (o_chan_valid[0] !== 1'b1 || o_chan_opc[15:0] !== 16'h0030 + 16'(i)) begin
        n_fail++; $display("FAIL fpp2_drain%0d got v=%b opc=%h exp v=1 opc=%h", i, o_chan_valid[0], o_chan_opc[15:0], 16'h0030 + 16'(i));
      end
      step();
    end
    i_chan_ready = 3'b000;
    n_tests++; if (o_chan_valid[0] !== 1'b0 || o_err !== 2'b00) begin n_fail++; $display("FAIL fpp2_end got v=%b err=%b exp v=0 err=00", o_chan_valid[0], o_err); end
  endtask

  task automatic test_independence();
    int pops;
    pops = 0;
    push(2'd0, 16'h0040);
    i_chan_ready = 3'b010;
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1; i_opc = 16'h0050 + 16'(i); i_lba = mk_lba(2'd1, 40'(i)); i_len = 24'(i);
      step();
      n_tests++;
      if (o_chan_valid !== 3'b011 || o_chan_opc[31:16] !== 16'h0050 + 16'(i) || o_chan_opc[15:0] !== 16'h0040) begin
        n_fail++; $display("FAIL indep%0d got v=%b opc1=%h opc0=%h exp v=011 opc1=%h opc0=0040", i, o_chan_valid, o_chan_opc[31:16], o_chan_opc[15:0], 16'h0050 + 16'(i));
      end
      if (o_chan_valid[1] && i_chan_ready[1]) pops++;
    end
    i_valid = 1'b0;
    step();
    n_tests++; if (pops !== 10 || o_chan_valid !== 3'b001) begin n_fail++; $display("FAIL indep_end got pops=%0d v=%b exp pops=10 v=001", pops, o_chan_valid); end
    i_chan_ready = 3'b001;
    step();
    i_chan_ready = 3'b000;
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL indep_drain got %b exp 0", o_busy); end
  endtask

  task automatic test_status();
    i_chan_sr = {8'h5A, 8'hE0, 8'hC0};
    i_chan_status = {2'b11, 2'b10, 2'b01};
    i_status_sel = 2'd0;
    step();
    n_tests++; if (o_sr !== 8'hC0 || o_status !== 2'b01) begin n_fail++; $display("FAIL stat0 got %h/%b exp C0/01", o_sr, o_status); end
    i_status_sel = 2'd1;
    #1;
    n_tests++; if (o_sr !== 8'hC0) begin n_fail++; $display("FAIL stat_lag got %h exp C0", o_sr); end
    step();
    n_tests++; if (o_sr !== 8'hE0 || o_status !== 2'b10) begin n_fail++; $display("FAIL stat1 got %h/%b exp E0/10", o_sr, o_status); end
    i_status_sel = 2'd2;
    step();
    n_tests++; if (o_sr !== 8'h5A || o_status !== 2'b11) begin n_fail++; $display("FAIL stat2 got %h/%b exp 5A/11", o_sr, o_status); end
    i_status_sel = 2'd3;
    step();
    n_tests++; if (o_sr !== 8'h00 || o_status !== 2'b00) begin n_fail++; $display("FAIL stat3 got %h/%b exp 00/00", o_sr, o_status); end
    i_status_sel = 2'd1;
    step();
  endtask

  task automatic test_reset_mid();
    push(2'd2, 16'h0061);
    push(2'd2, 16'h0062);
    n_tests++; if (o_chan_valid !== 3'b100 || o_chan_opc[47:32] !== 16'h0061) begin n_fail++; $display("FAIL rm_queued got v=%b opc=%h exp v=100 opc=0061", o_chan_valid, o_chan_opc[47:32]); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({o_chan_valid, o_busy, o_sr, o_status} !== '0) begin n_fail++; $display("FAIL rm_async got v=%b b=%b sr=%h st=%b exp 0", o_chan_valid, o_busy, o_sr, o_status); end
    n_tests++; if (o_chan_opc !== '0 || o_chan_len !== '0) begin n_fail++; $display("FAIL rm_data got %h exp 0", o_chan_opc); end
    step();
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (o_chan_valid !== 3'b000 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rm_replay%0d got v=%b b=%b exp 000/0", i, o_chan_valid, o_busy); end
    end
  endtask

  initial begin
    i_valid = 1'b0; i_opc = '0; i_lba = '0; i_len = '0;
    i_chan_ready = '0; i_chan_sr = '0; i_chan_status = '0;
    i_status_sel = '0; i_err_clr = 1'b0; rst_n = 1'b1;
    #2;
    test_reset();
    test_single();
    test_overflow();
    test_bad_channel();
    test_full_plus_pop();
    test_independence();
    test_status();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
